// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-sharing one WIDTH-bit adder among four requesters.
// Two register stages (operands, then sum); the response path has no backpressure.
module adder_arbiter #(
   parameter int WIDTH = 95,
   parameter int NREQ  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic                    resp_valid,
   output logic [1:0]              resp_id,
   output logic [WIDTH:0]          resp_sum,
   output logic [1:0]              inflight
);

   logic [1:0]       r_last;
   logic [NREQ-1:0]  w_grant;
   logic [1:0]       w_gnt_id;
   logic [1:0]       w_cand;
   logic             w_found;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic             w_xfer;

   logic             r_s1_vld;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [1:0]       r_s1_id;
   logic             r_s2_vld;
   logic [WIDTH:0]   r_s2_sum;
   logic [1:0]       r_s2_id;
   logic [1:0]       r_inflight;

   // Search starts one past the last winner; the 2-bit candidate wraps 3->0.
   always_comb begin
      w_grant  = '0;
      w_gnt_id = '0;
      w_cand   = '0;
      w_found  = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = r_last + 2'(k);
         if (!w_found && req_valid[w_cand]) begin
            w_found  = 1'b1;
            w_gnt_id = w_cand;
         end
      end
      if (w_found && rst_n) begin
         w_grant[w_gnt_id] = 1'b1;
      end
   end

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_a = req_a[i*WIDTH +: WIDTH];
            w_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign req_ready = w_grant;
   assign w_xfer    = |w_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 2'd3;
      end else if (w_xfer) begin
         r_last <= w_gnt_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s1_id  <= '0;
      end else begin
         r_s1_vld <= w_xfer;
         if (w_xfer) begin
            r_s1_a  <= w_a;
            r_s1_b  <= w_b;
            r_s1_id <= w_gnt_id;
         end
      end
   end

   // Sum and id only load on a valid stage-1 so they hold between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld <= 1'b0;
         r_s2_sum <= '0;
         r_s2_id  <= '0;
      end else begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_sum <= {1'b0, r_s1_a} + {1'b0, r_s1_b};
            r_s2_id  <= r_s1_id;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= '0;
      end else begin
         case ({w_xfer, r_s2_vld})
            2'b10:   r_inflight <= r_inflight + 2'd1;
            2'b01:   r_inflight <= r_inflight - 2'd1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign resp_valid = r_s2_vld;
   assign resp_id    = r_s2_id;
   assign resp_sum   = r_s2_sum;
   assign inflight   = r_inflight;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_adder_arbiter;
   localparam int W = 95;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic           resp_valid;
   logic [1:0]     resp_id;
   logic [W:0]     resp_sum;
   logic [1:0]     inflight;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
      .resp_sum(resp_sum), .inflight(inflight)
   );

   typedef struct {
      int         due;
      logic [1:0] id;
      logic [W:0] sum;
   } exp_t;

   exp_t         pend[$];
   int           m_last = 3;
   logic [W:0]   m_sum = '0;
   logic [1:0]   m_id = '0;
   int           k = 0;
   int           gnt_log[$];
   logic [W+2:0] resp_log[$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change only at posedge+1, so what is seen here is what the next edge samples.
   always @(negedge clk) begin : model
      logic [N-1:0] e_rdy;
      int           g;
      int           c;
      logic         m_vld;
      exp_t         e;
      k++;
      if (!rst_n) begin
         pend.delete();
         m_last = 3;
         m_sum  = '0;
         m_id   = '0;
      end
      while (pend.size() > 0 && pend[0].due < k) void'(pend.pop_front());
      m_vld = (pend.size() > 0) && (pend[0].due == k);
      if (m_vld) begin
         m_sum = pend[0].sum;
         m_id  = pend[0].id;
      end
      e_rdy = '0;
      g = -1;
      if (rst_n) begin
         for (int j = 1; j <= N; j++) begin
            c = (m_last + j) % N;
            if (g < 0 && req_valid[c]) g = c;
         end
      end
      if (g >= 0) e_rdy[g] = 1'b1;

      chk("req_ready", 128'(req_ready), 128'(e_rdy));
      chk("resp_valid", 128'(resp_valid), 128'(m_vld));
      chk("resp_id", 128'(resp_id), 128'(m_id));
      chk("resp_sum", 128'(resp_sum), 128'(m_sum));
      chk("inflight", 128'(inflight), 128'(pend.size()));

      if (rst_n && req_ready != '0) gnt_log.push_back($clog2(req_ready));
      if (resp_valid) resp_log.push_back({resp_id, resp_sum});

      if (g >= 0) begin
         e.due = k + 2;
         e.id  = 2'(g);
         e.sum = (W+1)'(req_a[g*W +: W]) + (W+1)'(req_b[g*W +: W]);
         pend.push_back(e);
         m_last = g;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic setr(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i]     = 1'b1;
      req_a[i*W +: W]  = a;
      req_b[i*W +: W]  = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      cyc(1);
      rst_n = 1'b1;
      gnt_log.delete();
      resp_log.delete();
   endtask

   initial begin : stim
      logic [W:0]   carry;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           n1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      cyc(3);
      rst_n = 1'b1;

      // Single request
      setr(0, 95'd5, 95'd7);
      cyc(1);
      req_valid = '0;
      cyc(4);
      chk("single_count", 128'(resp_log.size()), 128'd1);
      chk("single_resp", 128'(resp_log[0]), {30'd0, 2'd0, 96'd12});

      // Carry-out
      resp_log.delete();
      setr(2, '1, 95'd1);
      cyc(1);
      req_valid = '0;
      cyc(4);
      carry = '0;
      carry[W] = 1'b1;
      chk("carry_resp", 128'(resp_log[0]), {30'd0, 2'd2, carry});

      // Full contention from the reset pointer
      do_reset();
      for (int i = 0; i < N; i++) setr(i, 95'(i), 95'd100);
      cyc(8);
      req_valid = '0;
      cyc(4);
      chk("cont_gnt_count", 128'(gnt_log.size()), 128'd8);
      chk("cont_resp_count", 128'(resp_log.size()), 128'd8);
      for (int i = 0; i < 8; i++) begin
         chk("cont_gnt", 128'(gnt_log[i]), 128'(i % 4));
         chk("cont_resp", 128'(resp_log[i]), {30'd0, 2'(i % 4), 96'(100 + i % 4)});
      end

      // Fairness after partial use
      do_reset();
      setr(1, 95'd1, 95'd1);
      cyc(1);
      req_valid = '0;
      setr(0, 95'd2, 95'd2);
      setr(3, 95'd3, 95'd3);
      cyc(2);
      req_valid = '0;
      cyc(3);
      chk("fair_g0", 128'(gnt_log[0]), 128'd1);
      chk("fair_g1", 128'(gnt_log[1]), 128'd3);
      chk("fair_g2", 128'(gnt_log[2]), 128'd0);

      // Reset mid-flight discards both operations
      do_reset();
      setr(0, 95'd10, 95'd10);
      setr(1, 95'd11, 95'd11);
      cyc(2);
      rst_n = 1'b0;
      req_valid = '0;
      cyc(1);
      rst_n = 1'b1;
      chk("midrst_no_resp", 128'(resp_log.size()), 128'd0);
      gnt_log.delete();
      for (int i = 0; i < N; i++) setr(i, 95'(i), 95'd1);
      cyc(1);
      req_valid = '0;
      cyc(4);
      chk("midrst_next_gnt", 128'(gnt_log[0]), 128'd0);
      chk("midrst_resp_count", 128'(resp_log.size()), 128'd1);

      // Withdraw before grant leaves no trace
      do_reset();
      setr(0, 95'd4, 95'd4);
      setr(1, 95'd9, 95'd9);
      cyc(1);
      req_valid = '0;
      cyc(5);
      n1 = 0;
      foreach (resp_log[i]) if (resp_log[i][W+2:W+1] == 2'd1) n1++;
      chk("withdraw_no_id1", 128'(n1), 128'd0);
      chk("withdraw_gnt_count", 128'(gnt_log.size()), 128'd1);

      // Randomised traffic with occasional reset
      for (int t = 0; t < 600; t++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         req_valid = N'($urandom());
         for (int i = 0; i < N; i++) begin
            ra = W'({$urandom(), $urandom(), $urandom()});
            rb = W'({$urandom(), $urandom(), $urandom()});
            if ($urandom_range(0, 7) == 0) ra = '1;
            req_a[i*W +: W] = ra;
            req_b[i*W +: W] = rb;
         end
         cyc(1);
      end
      rst_n = 1'b1;
      req_valid = '0;
      cyc(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
